// File: rtl/limit_tick_shifter.sv
// limit_tick_shifter
//
// Consumer side of the constant-select mux. A free-running counter wraps
// whenever it reaches the selected period constant. Each wrap produces a
// one-cycle tick and advances an LED pattern register.
//
// Parameters
//   DATA_WIDTH : width of the limit constant and of the counter (matches mux)
//   N_LEDS     : width of the LED pattern, must be at least 2
//
// Ports
//   i_clk    : system clock, every state update happens on its rising edge
//   i_reset  : asynchronous active-high reset, released on the next edge
//   i_enable : count enable; low freezes counter and pattern, forces tick low
//   i_limit  : terminal count, sampled every cycle
//   i_mode   : pattern mode (00 rotate left, 01 rotate right,
//              10 ping-pong, 11 flash)
//   o_tick   : registered one-cycle pulse at each terminal count
//   o_leds   : registered LED pattern, updated on the same edge as o_tick
//   o_count  : current counter value
module limit_tick_shifter #(
  parameter int DATA_WIDTH = 32,
  parameter int N_LEDS     = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_limit,
  input  logic [1:0]            i_mode,
  output logic                  o_tick,
  output logic [N_LEDS-1:0]     o_leds,
  output logic [DATA_WIDTH-1:0] o_count
);

  typedef enum logic [1:0] {
    MODE_ROT_LEFT  = 2'b00,
    MODE_ROT_RIGHT = 2'b01,
    MODE_PING_PONG = 2'b10,
    MODE_FLASH     = 2'b11
  } mode_e;

  // Ping-pong travel direction. "Left" moves the lit LED towards the MSB.
  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [N_LEDS-1:0]     LED_HOME  = {{(N_LEDS-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] COUNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic                  tick_q, tick_d;
  logic [N_LEDS-1:0]     leds_q, leds_d;
  dir_e                  dir_q, dir_d;

  mode_e                 mode;
  logic                  atLimit;
  logic                  isOneHot;
  logic [N_LEDS-1:0]     nextLeds;
  dir_e                  nextDir;
  logic                  goRight;

  assign mode = mode_e'(i_mode);

  // Greater-or-equal rather than equal, so a limit lowered below the current
  // count wraps immediately instead of running all the way round.
  assign atLimit = (count_q >= i_limit);

  // Exactly one bit set: non-zero and clearing the lowest set bit gives zero.
  assign isOneHot = (leds_q != '0) && ((leds_q & (leds_q - LED_HOME)) == '0);

  // Pattern that would be loaded if a tick happened this cycle. The shifting
  // modes cannot make progress from an all-zero or all-one pattern (left
  // behind by flash mode), so those restart from the LSB heading left.
  always_comb begin
    nextLeds = leds_q;
    nextDir  = dir_q;
    goRight  = 1'b0;
    case (mode)
      MODE_FLASH: begin
        nextLeds = (leds_q == '1) ? '0 : '1;
      end
      MODE_ROT_LEFT: begin
        if (!isOneHot) begin
          nextLeds = LED_HOME;
          nextDir  = DIR_LEFT;
        end else begin
          nextLeds = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
        end
      end
      MODE_ROT_RIGHT: begin
        if (!isOneHot) begin
          nextLeds = LED_HOME;
          nextDir  = DIR_LEFT;
        end else begin
          nextLeds = {leds_q[0], leds_q[N_LEDS-1:1]};
        end
      end
      default: begin
        if (!isOneHot) begin
          nextLeds = LED_HOME;
          nextDir  = DIR_LEFT;
        end else begin
          // An LED already sitting on an end can only move inwards; this
          // matters when ping-pong is entered from a rotate mode with the
          // stored direction pointing off the edge.
          if (leds_q[N_LEDS-1]) begin
            goRight = 1'b1;
          end else if (leds_q[0]) begin
            goRight = 1'b0;
          end else begin
            goRight = (dir_q == DIR_RIGHT);
          end
          nextLeds = goRight ? (leds_q >> 1) : (leds_q << 1);
          // Turning around as soon as an end is reached means the end LED
          // is shown for exactly one tick.
          if (nextLeds[N_LEDS-1]) begin
            nextDir = DIR_RIGHT;
          end else if (nextLeds[0]) begin
            nextDir = DIR_LEFT;
          end else begin
            nextDir = goRight ? DIR_RIGHT : DIR_LEFT;
          end
        end
      end
    endcase
  end

  // Counter and tick next-state. The pattern and direction only move on the
  // tick edge, so o_tick and the new o_leds appear together.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    leds_d  = leds_q;
    dir_d   = dir_q;
    if (i_enable) begin
      if (atLimit) begin
        count_d = '0;
        tick_d  = 1'b1;
        leds_d  = nextLeds;
        dir_d   = nextDir;
      end else begin
        count_d = count_q + COUNT_ONE;
      end
    end
  end

  // State registers; reset takes priority over any tick on the same edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      leds_q  <= LED_HOME;
      dir_q   <= DIR_LEFT;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      leds_q  <= leds_d;
      dir_q   <= dir_d;
    end
  end

  assign o_tick  = tick_q;
  assign o_leds  = leds_q;
  assign o_count = count_q;

endmodule

// File: doc/limit_tick_shifter.md
Name: limit_tick_shifter

Overview:
- Consumer side of the constant-select mux: takes the selected DATA_WIDTH-bit period constant (e.g. 3/10/100/5000) and turns it into a periodic tick.
- Each tick advances an LED pattern register.
- Sits between the switch-driven mux output and the board LEDs. Fully synchronous to i_clk.

Parameters:
- DATA_WIDTH, 32, width of i_limit and o_count; matches the mux data width.
- N_LEDS, 4, width of the LED pattern; must be >= 2.

Ports:
- i_clk  input  1  system clock, all state updates on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_enable  input  1  count enable; low freezes counter and pattern.
- i_limit  input  DATA_WIDTH  terminal count, sampled every cycle (from mux o_mux_data).
- i_mode  input  2  pattern mode: 00 rotate left, 01 rotate right, 10 ping-pong, 11 flash.
- o_tick  output  1  registered one-cycle pulse at each terminal count.
- o_leds  output  N_LEDS  registered LED pattern.
- o_count  output  DATA_WIDTH  current counter value (debug/verification).

Behaviour:
- Reset (async assert, any time, including mid-count):
  - o_count=0, o_tick=0, o_leds={0..0,1} (LSB one-hot).
  - Ping-pong direction register = left.
  - Release is synchronous to next edge.
- Counter, each rising edge with i_enable=1:
  - If o_count >= i_limit: o_count<=0, o_tick<=1, pattern advances.
  - Else: o_count<=o_count+1, o_tick<=0.
  - Unsigned compare, DATA_WIDTH bits.
  - No overflow possible because wrap occurs at limit.
- i_enable=0: o_count and o_leds hold, o_tick<=0.
- Period: steady limit L with enable held high gives a tick every L+1 cycles.
  - First tick is visible in the cycle after the (L+1)-th enabled edge following reset release.
- i_limit=0: tick every enabled cycle; o_count stays 0.
- i_limit lowered below current o_count mid-count: the >= compare wraps on the next enabled edge (tick issued). No hang waiting for 2^DATA_WIDTH.
- i_limit raised mid-count: counting continues to the new limit.
- Pattern update:
  - Happens on the same edge that sets o_tick, so o_tick=1 coincides with the new o_leds value.
  - The mode used is i_mode sampled on that edge.
  - 00: rotate left, MSB wraps to LSB.
  - 01: rotate right, LSB wraps to MSB.
  - 10 ping-pong: shift in the current direction.
    - If the result lands on MSB, direction<=right. If it lands on LSB, direction<=left.
    - The end LED is shown once, never twice consecutively.
  - 11 flash: if o_leds == all ones then o_leds<=all zeros, else o_leds<=all ones.
- Mode change:
  - Takes effect at the next tick only; a mid-period change does not alter o_leds immediately.
  - Entering modes 00/01/10 with a non-one-hot pattern (all zeros or all ones from flash): that tick loads {0..0,1} instead of shifting, and sets direction=left.
- Ping-pong direction register changes only in mode 10 or on the one-hot recovery load above.
- Simultaneous reset and tick: reset wins.

Test Plan:
- Reset then enable=1, limit=3, mode=00, N_LEDS=4 -> o_tick high every 4 cycles. o_count sequence 0,1,2,3,0. o_leds 0001->0010->0100->1000->0001 on successive ticks.
- Mode=10, limit=0 -> tick every cycle; o_leds 0001,0010,0100,1000,0100,0010,0001,0010 (no repeated end LED).
- Mode=11 from 0001, limit=1 -> o_leds 1111,0000,1111 every 2 cycles. Switch mode to 01 while o_leds=0000 -> next tick loads 0001, following tick 1000.
- Limit=10, let o_count reach 7, change limit to 3 -> tick on next edge, o_count 0, then ticks every 4 cycles.
- Limit=5, toggle enable low for 6 cycles at o_count=2 -> o_count holds 2, no tick. Resume gives tick 4 enabled edges later.
- Assert i_reset asynchronously mid-period (between clock edges) with o_leds=0100 -> outputs immediately 0/0/0001. After release, first tick after limit+1 enabled edges.
